interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/common_types_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/interrupt_controller.sv | 103 ++++++++++
 3 files changed

// File: rtl/common_types_pkg.sv
// Shared types for the interrupt controller: line count, line index type,
// FSM state encoding and the priority helper used by arbitration.
package common_types_pkg;

    localparam int IRQ_LINES = 32;

    typedef logic [4:0] irq_id_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2
    } irqc_state_t;

    // Highest set bit wins; later iterations overwrite earlier ones.
    function automatic irq_id_t highest_set(input logic [IRQ_LINES-1:0] vec);
        irq_id_t id;
        id = '0;
        for (int i = 0; i < IRQ_LINES; i++) begin
            if (vec[i]) id = irq_id_t'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bundle of independent asynchronous lines.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronizes raw lines, keeps sticky edge pending bits,
// arbitrates highest-numbered eligible line and sequences present/service.
module interrupt_controller
    import common_types_pkg::*;
#(
    parameter int NUM_IRQ = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NUM_IRQ-1:0]   irq_in,
    input  logic [NUM_IRQ-1:0]   edge_mode,
    input  logic [IRQ_LINES-1:0] mie,
    input  logic                 interrupt_en,
    input  logic                 ack,
    input  logic                 complete,
    input  irq_id_t              complete_id,
    output logic [IRQ_LINES-1:0] irq_pending,
    output logic                 irq_valid,
    output irq_id_t              irq_id,
    output logic                 in_service
);

    logic [NUM_IRQ-1:0]   sync_s2;
    logic [NUM_IRQ-1:0]   s3_q;
    logic [NUM_IRQ-1:0]   edge_pend_q;
    logic [NUM_IRQ-1:0]   edge_pend_d;
    logic [NUM_IRQ-1:0]   edge_set;
    logic [IRQ_LINES-1:0] clr_vec;
    logic [IRQ_LINES-1:0] eligible;

    irqc_state_t state_q, state_d;
    irq_id_t     irq_id_q, irq_id_d;
    logic        irq_valid_q, irq_valid_d;
    logic        in_service_q, in_service_d;

    sync_2ff #(.WIDTH(NUM_IRQ)) u_sync (
        .clk   (CLK),
        .rst_n (nRST),
        .d     (irq_in),
        .q     (sync_s2)
    );

    always_comb begin
        irq_pending = '0;
        irq_pending[NUM_IRQ-1:0] = (edge_mode & edge_pend_q) | (~edge_mode & sync_s2);
    end

    assign eligible = irq_pending & mie & {IRQ_LINES{interrupt_en}};
    assign edge_set = sync_s2 & ~s3_q & edge_mode;

    // A fresh edge landing on the clearing cycle must survive, so set is OR'd last.
    always_comb begin
        clr_vec = '0;
        if (state_q == PRESENT && ack) clr_vec[irq_id_q] = 1'b1;
        edge_pend_d = (edge_pend_q & ~clr_vec[NUM_IRQ-1:0]) | edge_set;
    end

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d  = PRESENT;
                    irq_id_d = highest_set(eligible);
                end
            end
            PRESENT: begin
                if (ack)                     state_d = SERVICE;
                else if (!eligible[irq_id_q]) state_d = IDLE;
            end
            SERVICE: begin
                if (complete && complete_id == irq_id_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        irq_valid_d  = (state_d == PRESENT);
        in_service_d = (state_d == SERVICE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s3_q         <= '0;
            edge_pend_q  <= '0;
            state_q      <= IDLE;
            irq_id_q     <= '0;
            irq_valid_q  <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            s3_q         <= sync_s2;
            edge_pend_q  <= edge_pend_d;
            state_q      <= state_d;
            irq_id_q     <= irq_id_d;
            irq_valid_q  <= irq_valid_d;
            in_service_q <= in_service_d;
        end
    end

    assign irq_valid  = irq_valid_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;

endmodule
